lsu_mem_sequencer: RTL

//  Sequences MEM-stage loads/stores (decoded mem_we / mem2rf) onto a variable-latency data bus with req/ack handshake.

---
 rtl/lsu_mem_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_sequencer
// Description : MEM-stage load/store sequencer. It issues one aligned
//               load or store per instruction on a req/ack data bus, holds
//               the pipeline while the access is outstanding, and returns
//               the load data for write-back. A misaligned access is dropped
//               and flagged with a one-cycle pulse.
// Options     : LSU_TIMEOUT_EN - abort a BUSY access after TIMEOUT_CYCLES
//               cycles without ack and report bus_err.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_sequencer #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mem_valid,
   input  logic            mem_we,
   input  logic            mem2rf,
   input  logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_wdata,
   output logic            mem_stall,
   output logic [XLEN-1:0] ld_data,
   output logic            ld_valid,
   output logic            misalign,
   output logic            bus_err,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_ack,
   input  logic [XLEN-1:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [XLEN-1:0]   bus_addr_q, bus_addr_d;
   logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;
   logic [XLEN-1:0]   ld_data_q, ld_data_d;
   logic              ld_valid_q, ld_valid_d;
   logic              misalign_q, misalign_d;

   logic              is_mem;
   logic              start;
   logic              misalign_det;
   logic              timeout_hit;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic              bus_err_q, bus_err_d;
`endif

   // A limit below one cycle cannot be honoured; no hardware is built for it.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unsupported
   end

   // Decode a new access; start is suppressed while reset is held so the
   // pipeline is never frozen during reset.
   always_comb begin
      is_mem       = mem_valid & (mem_we | mem2rf);
      start        = rst_n & is_mem & (mem_addr[1:0] == 2'b00) & (state_q == S_IDLE);
      misalign_det = is_mem & (mem_addr[1:0] != 2'b00) & (state_q == S_IDLE);
   end

   // Abort condition: the last allowed BUSY cycle passes without ack.
`ifdef LSU_TIMEOUT_EN
   always_comb begin
      timeout_hit = (state_q == S_BUSY) & ~bus_ack &
                    (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   end
`else
   always_comb begin
      timeout_hit = 1'b0;
   end
`endif

   // Next-state and next-register values for the access sequencer.
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      ld_data_d   = ld_data_q;
      ld_valid_d  = 1'b0;
      misalign_d  = misalign_det;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_d   = tmo_cnt_q;
      bus_err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_BUSY;
               bus_req_d   = 1'b1;
               // A load+store decode is treated as a store.
               bus_we_d    = mem_we;
               bus_addr_d  = mem_addr;
               bus_wdata_d = mem_wdata;
`ifdef LSU_TIMEOUT_EN
               tmo_cnt_d   = '0;
`endif
            end
         end
         S_BUSY: begin
            // An ack on the limit cycle wins over the timeout.
            if (bus_ack) begin
               state_d   = S_DONE;
               bus_req_d = 1'b0;
               if (!bus_we_q) begin
                  ld_data_d  = bus_rdata;
                  ld_valid_d = 1'b1;
               end
            end else if (timeout_hit) begin
               state_d   = S_DONE;
               bus_req_d = 1'b0;
`ifdef LSU_TIMEOUT_EN
               bus_err_d = 1'b1;
`endif
            end else begin
`ifdef LSU_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any outstanding access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         ld_data_q   <= '0;
         ld_valid_q  <= 1'b0;
         misalign_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         bus_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         ld_data_q   <= ld_data_d;
         ld_valid_q  <= ld_valid_d;
         misalign_q  <= misalign_d;
`ifdef LSU_TIMEOUT_EN
         tmo_cnt_q   <= tmo_cnt_d;
         bus_err_q   <= bus_err_d;
`endif
      end
   end

   assign mem_stall = start | (state_q == S_BUSY);
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign ld_data   = ld_data_q;
   assign ld_valid  = ld_valid_q;
   assign misalign  = misalign_q;
`ifdef LSU_TIMEOUT_EN
   assign bus_err   = bus_err_q;
`else
   assign bus_err   = 1'b0;
`endif

endmodule
`default_nettype wire
